// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter : VGA-priority arbiter sharing one single-port text VRAM with the CPU.
//                Optional VRAM_POST_WR_EN adds a one-entry posted-write buffer.
// Revision     : 1.0
// ============================================================================
module vram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  output logic          vga_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starve,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    V_ADDR = 3'd1,
    V_DATA = 3'd2,
    C_ADDR = 3'd3,
    C_DATA = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t        state;
  logic          vga_pend;
  logic [AW-1:0] pend_addr;
  logic          cur_we;
  logic [3:0]    wait_cnt;

  logic          at_decision;
  logic          vga_go;
  logic          cpu_go;
  logic          cpu_issue;
  logic          cpu_busy;
  logic          ack_set;
  logic          drain;
  logic [AW-1:0] src_addr;
  logic          src_we;
  logic [DW-1:0] src_wdata;

  assign at_decision = (state == IDLE) || (state == V_DATA) || (state == C_DATA);
  assign vga_go      = at_decision && (vga_req || vga_pend);
  // C_DATA belongs to the CPU access that is finishing, so it never re-issues the CPU.
  assign cpu_issue   = at_decision && !vga_go && cpu_go && (state != C_DATA);
  assign cpu_busy    = ((state == C_ADDR) || (state == C_DATA)) && !drain;
  assign cpu_starve  = (wait_cnt == STARVE_LIM);

`ifdef VRAM_POST_WR_EN
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic          post_accept;

  assign post_accept = cpu_req && cpu_we && !cpu_ack && !buf_valid;
  // Reads wait behind a full buffer, which keeps read-after-write order.
  assign cpu_go      = buf_valid || (cpu_req && !cpu_we && !cpu_ack);
  assign src_addr    = buf_valid ? buf_addr : cpu_addr;
  assign src_we      = buf_valid;
  assign src_wdata   = buf_wdata;
  assign ack_set     = post_accept || ((state == C_DATA) && !drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      drain     <= 1'b0;
    end else begin
      if (post_accept) begin
        buf_valid <= 1'b1;
        buf_addr  <= cpu_addr;
        buf_wdata <= cpu_wdata;
      end else if ((state == C_DATA) && drain) begin
        buf_valid <= 1'b0;
      end
      if (cpu_issue) begin
        drain <= buf_valid;
      end
    end
  end
`else
  assign drain     = 1'b0;
  assign cpu_go    = cpu_req && !cpu_ack;
  assign src_addr  = cpu_addr;
  assign src_we    = cpu_we;
  assign src_wdata = cpu_wdata;
  assign ack_set   = (state == C_DATA);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vga_pend  <= 1'b0;
      pend_addr <= '0;
      cur_we    <= 1'b0;
      wait_cnt  <= '0;
      vga_data  <= '0;
      vga_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we    <= 1'b0;
      vga_valid <= 1'b0;
      cpu_ack   <= ack_set;

      if (state == V_DATA) begin
        vga_data  <= mem_rdata;
        vga_valid <= 1'b1;
      end
      if ((state == C_DATA) && !cur_we) begin
        cpu_rdata <= mem_rdata;
      end

      // A strobe outside a decision point is parked; a second one while parked is dropped.
      if (vga_go) begin
        vga_pend <= 1'b0;
      end else if (vga_req && !vga_pend) begin
        vga_pend  <= 1'b1;
        pend_addr <= vga_addr;
      end

      case (state)
        V_ADDR:  state <= V_DATA;
        C_ADDR:  state <= C_DATA;
        default: begin
          if (vga_go) begin
            state    <= V_ADDR;
            mem_addr <= vga_pend ? pend_addr : vga_addr;
          end else if (cpu_issue) begin
            state     <= C_ADDR;
            mem_addr  <= src_addr;
            mem_we    <= src_we;
            mem_wdata <= src_wdata;
            cur_we    <= src_we;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (ack_set) begin
        wait_cnt <= '0;
      end else if (cpu_req && !cpu_ack && !cpu_busy && (wait_cnt != STARVE_LIM)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
